// File: rtl/issue_controller_pkg.sv
// Shared definitions for the issue controller.
// Holds the FSM state encoding, the execute-unit busy levels and a small
// helper that turns a register address into a one-hot bitmap mask.
package issue_controller_pkg;

    // RUN issues normally, WAIT_EX holds for a multi-cycle unit, DRAIN waits
    // for all pending writes before a serializing instruction. Code 3 is never
    // entered and falls back to RUN.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT_EX = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_UNUSED  = 2'd3
    } state_e;

    localparam logic EXECUTE_IS_WORKING  = 1'b1;
    localparam logic EXECUTE_NOT_WORKING = 1'b0;

    // One-hot mask for a 5-bit register address.
    function automatic logic [31:0] reg_mask(input logic [4:0] addr);
        reg_mask = 32'd1 << addr;
    endfunction

endpackage

// File: rtl/scoreboard_bank.sv
// Pending-write bitmap for one register file.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   set_en_i / set_addr_i   mark a register as having a write in flight
//   clr_en_i / clr_addr_i   writeback completed for a register
//   bitmap_o                current pending bitmap (registered)
// ZERO_REG=1 pins bit 0 to zero (hard-wired x0 of the integer file).
// A set and a clear of the same bit on one edge leave the bit set: the new
// producer supersedes the retiring one.
module scoreboard_bank
    import issue_controller_pkg::*;
#(
    parameter logic ZERO_REG = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        set_en_i,
    input  logic [4:0]  set_addr_i,
    input  logic        clr_en_i,
    input  logic [4:0]  clr_addr_i,
    output logic [31:0] bitmap_o
);

    logic [31:0] bitmap_r;
    logic [31:0] set_mask_s;
    logic [31:0] clr_mask_s;
    logic [31:0] keep_mask_s;
    logic [31:0] bitmap_next_s;

    // Next bitmap: clear first, then set, so set wins on a collision.
    always_comb begin
        set_mask_s    = set_en_i ? reg_mask(set_addr_i) : 32'd0;
        clr_mask_s    = clr_en_i ? reg_mask(clr_addr_i) : 32'd0;
        keep_mask_s   = ZERO_REG ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;
        bitmap_next_s = ((bitmap_r & ~clr_mask_s) | set_mask_s) & keep_mask_s;
    end

    // Bitmap register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bitmap_r <= 32'd0;
        end else begin
            bitmap_r <= bitmap_next_s;
        end
    end

    assign bitmap_o = bitmap_r;

endmodule

// File: rtl/issue_controller.sv
// In-order issue controller between decode and execute.
// Tracks pending register writes for the integer and float files, detects
// RAW/WAW hazards (with same-cycle writeback bypass for RAW), handles
// multi-cycle execute units and serializing instructions, and counts stall
// cycles with a saturating counter.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   coz_*                        decoded instruction and its register usage
//   execute_working_info_i       execute unit busy
//   writeback_*                  completing register write
//   flush_i                      kill the instruction in decode
//   yurut_gonder_o               issue strobe (combinational in RUN)
//   decode_working_info_o        decode stalled (valid && !issue)
//   int_bekleyen_o/float_bekleyen_o  pending-write bitmaps
//   durak_sayaci_o               saturating stall counter
//   durum_o                      FSM state
module issue_controller
    import issue_controller_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   coz_gecerli_i,
    input  logic [14:0]            coz_rs_i,
    input  logic [2:0]             coz_rs_kullan_i,
    input  logic [2:0]             coz_rs_float_i,
    input  logic [4:0]             coz_rd_i,
    input  logic                   coz_rd_yaz_i,
    input  logic                   coz_rd_float_i,
    input  logic                   coz_cok_cevrim_i,
    input  logic                   coz_serilestir_i,
    input  logic                   execute_working_info_i,
    input  logic                   writeback_enable_i,
    input  logic [4:0]             writeback_address_i,
    input  logic                   writeback_float_i,
    input  logic                   flush_i,
    output logic                   yurut_gonder_o,
    output logic                   decode_working_info_o,
    output logic [31:0]            int_bekleyen_o,
    output logic [31:0]            float_bekleyen_o,
    output logic [STALL_CNT_W-1:0] durak_sayaci_o,
    output logic [1:0]             durum_o
);

    state_e                 state_r;
    logic                   wait_entry_r;
    logic [STALL_CNT_W-1:0] stall_cnt_r;

    logic [31:0] int_bm_s;
    logic [31:0] fp_bm_s;
    logic        bitmaps_zero_s;
    logic        hazard_s;
    logic [4:0]  src_addr_s;
    logic        src_pend_s;
    logic        src_wb_hit_s;
    logic        issue_s;
    logic        stall_s;

    assign bitmaps_zero_s = (int_bm_s == 32'd0) && (fp_bm_s == 32'd0);

    // RAW on used sources (bypassed by a same-cycle writeback) plus WAW on rd.
    // Integer x0 never carries a pending bit, so it can never hazard.
    always_comb begin
        hazard_s     = 1'b0;
        src_addr_s   = 5'd0;
        src_pend_s   = 1'b0;
        src_wb_hit_s = 1'b0;
        for (int i = 0; i < 3; i++) begin
            src_addr_s   = coz_rs_i[i*5 +: 5];
            src_wb_hit_s = writeback_enable_i
                           && (writeback_float_i == coz_rs_float_i[i])
                           && (writeback_address_i == src_addr_s);
            if (coz_rs_float_i[i]) begin
                src_pend_s = fp_bm_s[src_addr_s];
            end else begin
                src_pend_s = int_bm_s[src_addr_s];
            end
            if (coz_rs_kullan_i[i] && src_pend_s && !src_wb_hit_s) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
        if (coz_rd_yaz_i && (coz_rd_float_i ? fp_bm_s[coz_rd_i] : int_bm_s[coz_rd_i])) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = hazard_s;
        end
    end

    // Issue decision; reset forces both strobes low.
    always_comb begin
        issue_s = !rst_i
                  && (state_r == ST_RUN)
                  && coz_gecerli_i
                  && !hazard_s
                  && (execute_working_info_i != EXECUTE_IS_WORKING)
                  && !flush_i
                  && (!coz_serilestir_i || bitmaps_zero_s);
        stall_s = !rst_i && coz_gecerli_i && !issue_s;
    end

    scoreboard_bank #(.ZERO_REG(1'b1)) u_int_bank (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .set_en_i   (issue_s && coz_rd_yaz_i && !coz_rd_float_i),
        .set_addr_i (coz_rd_i),
        .clr_en_i   (writeback_enable_i && !writeback_float_i),
        .clr_addr_i (writeback_address_i),
        .bitmap_o   (int_bm_s)
    );

    scoreboard_bank #(.ZERO_REG(1'b0)) u_float_bank (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .set_en_i   (issue_s && coz_rd_yaz_i && coz_rd_float_i),
        .set_addr_i (coz_rd_i),
        .clr_en_i   (writeback_enable_i && writeback_float_i),
        .clr_addr_i (writeback_address_i),
        .bitmap_o   (fp_bm_s)
    );

    // Issue FSM. The execute busy flag may still reflect the previous
    // operation on the cycle WAIT_EX is entered, so that cycle is skipped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= ST_RUN;
            wait_entry_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (issue_s && coz_cok_cevrim_i) begin
                        state_r      <= ST_WAIT_EX;
                        wait_entry_r <= 1'b1;
                    end else if (coz_gecerli_i && coz_serilestir_i
                                 && !bitmaps_zero_s && !flush_i) begin
                        state_r      <= ST_DRAIN;
                        wait_entry_r <= 1'b0;
                    end else begin
                        state_r      <= ST_RUN;
                        wait_entry_r <= 1'b0;
                    end
                end
                ST_WAIT_EX: begin
                    if (wait_entry_r) begin
                        state_r      <= ST_WAIT_EX;
                        wait_entry_r <= 1'b0;
                    end else if (execute_working_info_i == EXECUTE_NOT_WORKING) begin
                        state_r      <= ST_RUN;
                        wait_entry_r <= 1'b0;
                    end else begin
                        state_r      <= ST_WAIT_EX;
                        wait_entry_r <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (flush_i || bitmaps_zero_s) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                    wait_entry_r <= 1'b0;
                end
                default: begin
                    state_r      <= ST_RUN;
                    wait_entry_r <= 1'b0;
                end
            endcase
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign yurut_gonder_o        = issue_s;
    assign decode_working_info_o = stall_s;
    assign int_bekleyen_o        = int_bm_s;
    assign float_bekleyen_o      = fp_bm_s;
    assign durak_sayaci_o        = stall_cnt_r;
    assign durum_o               = state_r;

endmodule

// File: tb/tb_issue_controller.sv
// Scoreboard bench for issue_controller. A stimulus process drives one
// cycle at a time, evaluates a register-array reference model and queues the
// expected outputs; a monitor pops and compares on every falling edge.
module tb_issue_controller;

    localparam int CW = 16;

    logic          clk_i;
    logic          rst_i;
    logic          coz_gecerli_i;
    logic [14:0]   coz_rs_i;
    logic [2:0]    coz_rs_kullan_i;
    logic [2:0]    coz_rs_float_i;
    logic [4:0]    coz_rd_i;
    logic          coz_rd_yaz_i;
    logic          coz_rd_float_i;
    logic          coz_cok_cevrim_i;
    logic          coz_serilestir_i;
    logic          execute_working_info_i;
    logic          writeback_enable_i;
    logic [4:0]    writeback_address_i;
    logic          writeback_float_i;
    logic          flush_i;
    logic          yurut_gonder_o;
    logic          decode_working_info_o;
    logic [31:0]   int_bekleyen_o;
    logic [31:0]   float_bekleyen_o;
    logic [CW-1:0] durak_sayaci_o;
    logic [1:0]    durum_o;

    issue_controller #(.STALL_CNT_W(CW)) dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .coz_gecerli_i          (coz_gecerli_i),
        .coz_rs_i               (coz_rs_i),
        .coz_rs_kullan_i        (coz_rs_kullan_i),
        .coz_rs_float_i         (coz_rs_float_i),
        .coz_rd_i               (coz_rd_i),
        .coz_rd_yaz_i           (coz_rd_yaz_i),
        .coz_rd_float_i         (coz_rd_float_i),
        .coz_cok_cevrim_i       (coz_cok_cevrim_i),
        .coz_serilestir_i       (coz_serilestir_i),
        .execute_working_info_i (execute_working_info_i),
        .writeback_enable_i     (writeback_enable_i),
        .writeback_address_i    (writeback_address_i),
        .writeback_float_i      (writeback_float_i),
        .flush_i                (flush_i),
        .yurut_gonder_o         (yurut_gonder_o),
        .decode_working_info_o  (decode_working_info_o),
        .int_bekleyen_o         (int_bekleyen_o),
        .float_bekleyen_o       (float_bekleyen_o),
        .durak_sayaci_o         (durak_sayaci_o),
        .durum_o                (durum_o)
    );

    typedef struct packed {
        logic        rst;
        logic        valid;
        logic [14:0] rs;
        logic [2:0]  use_;
        logic [2:0]  fl;
        logic [4:0]  rd;
        logic        rd_yaz;
        logic        rd_fl;
        logic        cok;
        logic        ser;
        logic        busy;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic        wb_fl;
        logic        flush;
    } stim_t;

    typedef struct packed {
        logic          issue;
        logic          stall;
        logic [31:0]   ibm;
        logic [31:0]   fbm;
        logic [1:0]    st;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: per-register pending flags, mode and stall count.
    localparam int M_RUN = 0, M_WAIT = 1, M_DRAIN = 2;
    bit ip[32];
    bit fp[32];
    int mode;
    bit fresh;
    int cnt;
    bit m_issued;

    int n_checks = 0;
    int n_fail   = 0;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Drive one cycle and queue the expected outputs for it.
    task automatic step(input stim_t s);
        exp_t        e;
        logic [31:0] iv, fv;
        bit          hz, allz, iss, p;
        int          a;
        @(posedge clk_i);
        #1;
        rst_i                  = s.rst;
        coz_gecerli_i          = s.valid;
        coz_rs_i               = s.rs;
        coz_rs_kullan_i        = s.use_;
        coz_rs_float_i         = s.fl;
        coz_rd_i               = s.rd;
        coz_rd_yaz_i           = s.rd_yaz;
        coz_rd_float_i         = s.rd_fl;
        coz_cok_cevrim_i       = s.cok;
        coz_serilestir_i       = s.ser;
        execute_working_info_i = s.busy;
        writeback_enable_i     = s.wb_en;
        writeback_address_i    = s.wb_addr;
        writeback_float_i      = s.wb_fl;
        flush_i                = s.flush;
        e = '0;
        if (s.rst) begin
            for (int i = 0; i < 32; i++) begin
                ip[i] = 0;
                fp[i] = 0;
            end
            mode = M_RUN; fresh = 0; cnt = 0; m_issued = 0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                iv[i] = ip[i];
                fv[i] = fp[i];
            end
            hz = 0;
            for (int i = 0; i < 3; i++) begin
                if (s.use_[i]) begin
                    a = int'(s.rs[5*i +: 5]);
                    p = s.fl[i] ? fp[a] : ip[a];
                    if (p && s.wb_en && (s.wb_fl == s.fl[i]) && (int'(s.wb_addr) == a)) p = 0;
                    if (p) hz = 1;
                end
            end
            if (s.rd_yaz && (s.rd_fl ? fp[s.rd] : ip[s.rd])) hz = 1;
            allz = (iv == 32'd0) && (fv == 32'd0);
            iss  = (mode == M_RUN) && s.valid && !hz && !s.busy && !s.flush && (!s.ser || allz);
            e.issue = iss;
            e.stall = s.valid && !iss;
            e.ibm   = iv;
            e.fbm   = fv;
            e.st    = mode[1:0];
            e.cnt   = cnt[CW-1:0];
            if (e.stall && cnt < (1 << CW) - 1) cnt++;
            if (s.wb_en) begin
                if (s.wb_fl) fp[s.wb_addr] = 0;
                else         ip[s.wb_addr] = 0;
            end
            if (iss && s.rd_yaz) begin
                if (s.rd_fl)          fp[s.rd] = 1;
                else if (s.rd != 5'd0) ip[s.rd] = 1;
            end
            case (mode)
                M_RUN: begin
                    if (iss && s.cok) begin
                        mode = M_WAIT; fresh = 1;
                    end else if (s.valid && s.ser && !allz && !s.flush) begin
                        mode = M_DRAIN;
                    end
                end
                M_WAIT: begin
                    if (fresh) fresh = 0;
                    else if (!s.busy) mode = M_RUN;
                end
                M_DRAIN: if (s.flush || allz) mode = M_RUN;
                default: mode = M_RUN;
            endcase
            m_issued = iss;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: compare every presented cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("issue",  {31'd0, yurut_gonder_o},        {31'd0, e.issue});
                chk("stall",  {31'd0, decode_working_info_o}, {31'd0, e.stall});
                chk("int_bm", int_bekleyen_o,                 e.ibm);
                chk("fp_bm",  float_bekleyen_o,               e.fbm);
                chk("state",  {30'd0, durum_o},               {30'd0, e.st});
                chk("cnt",    {16'd0, durak_sayaci_o},        {16'd0, e.cnt});
            end
        end
    end

    task automatic do_reset();
        stim_t s;
        s = idle();
        s.rst = 1'b1;
        step(s);
        step(s);
    endtask

    initial begin
        stim_t s;
        stim_t cur;
        bit    have;
        int    plist[$];
        rst_i = 1'b1; coz_gecerli_i = 1'b0; coz_rs_i = 15'd0; coz_rs_kullan_i = 3'd0;
        coz_rs_float_i = 3'd0; coz_rd_i = 5'd0; coz_rd_yaz_i = 1'b0; coz_rd_float_i = 1'b0;
        coz_cok_cevrim_i = 1'b0; coz_serilestir_i = 1'b0; execute_working_info_i = 1'b0;
        writeback_enable_i = 1'b0; writeback_address_i = 5'd0; writeback_float_i = 1'b0;
        flush_i = 1'b0;

        do_reset();

        // Writeback bypass resolves a RAW stall.
        s = idle(); s.valid = 1; s.rd = 5'd5; s.rd_yaz = 1;
        step(s); @(negedge clk_i); chk("bypass_first_issue", {31'd0, yurut_gonder_o}, 32'd1);
        s = idle(); s.valid = 1; s.rs = {5'd0, 5'd1, 5'd5}; s.use_ = 3'b011; s.rd = 5'd6; s.rd_yaz = 1;
        step(s); @(negedge clk_i); chk("bypass_stall", {31'd0, decode_working_info_o}, 32'd1);
        s.wb_en = 1; s.wb_addr = 5'd5;
        step(s); @(negedge clk_i); chk("bypass_issue", {31'd0, yurut_gonder_o}, 32'd1);
        step(idle()); @(negedge clk_i); chk("bypass_bitmap", int_bekleyen_o, 32'h40);

        // Multi-cycle execute unit.
        do_reset();
        s = idle(); s.valid = 1; s.rd = 5'd7; s.rd_yaz = 1; s.cok = 1;
        step(s); @(negedge clk_i); chk("div_issue", {31'd0, yurut_gonder_o}, 32'd1);
        s = idle(); s.valid = 1; s.rd = 5'd8; s.rd_yaz = 1; s.busy = 1;
        for (int k = 0; k < 4; k++) begin
            step(s); @(negedge clk_i);
            chk("waitex_state", {30'd0, durum_o}, 32'd1);
            chk("waitex_no_issue", {31'd0, yurut_gonder_o}, 32'd0);
        end
        s.busy = 0;
        step(s); @(negedge clk_i); chk("waitex_last", {31'd0, yurut_gonder_o}, 32'd0);
        step(s); @(negedge clk_i);
        chk("waitex_back_run", {30'd0, durum_o}, 32'd0);
        chk("waitex_after_issue", {31'd0, yurut_gonder_o}, 32'd1);

        // Serializing fence drains a pending float write.
        do_reset();
        s = idle(); s.valid = 1; s.rd = 5'd3; s.rd_yaz = 1; s.rd_fl = 1;
        step(s);
        s = idle(); s.valid = 1; s.ser = 1;
        step(s); @(negedge clk_i); chk("fence_held", {31'd0, yurut_gonder_o}, 32'd0);
        s.wb_en = 1; s.wb_addr = 5'd3; s.wb_fl = 1;
        step(s); @(negedge clk_i); chk("drain_state", {30'd0, durum_o}, 32'd2);
        s.wb_en = 0; s.wb_addr = 5'd0; s.wb_fl = 0;
        step(s); @(negedge clk_i); chk("drain_exit_cycle", {31'd0, yurut_gonder_o}, 32'd0);
        step(s); @(negedge clk_i); chk("fence_issue", {31'd0, yurut_gonder_o}, 32'd1);

        // Set and clear of the same bit on one edge.
        do_reset();
        s = idle(); s.valid = 1; s.rd = 5'd9; s.rd_yaz = 1; s.wb_en = 1; s.wb_addr = 5'd9;
        step(s);
        step(idle()); @(negedge clk_i); chk("set_wins", int_bekleyen_o, 32'h200);

        // x0 never becomes pending.
        do_reset();
        s = idle(); s.valid = 1; s.rd = 5'd0; s.rd_yaz = 1;
        step(s);
        step(idle()); @(negedge clk_i); chk("x0_not_pending", int_bekleyen_o, 32'd0);
        s = idle(); s.valid = 1; s.use_ = 3'b001; s.rd = 5'd0; s.rd_yaz = 1;
        step(s); @(negedge clk_i); chk("x0_dep_issue", {31'd0, yurut_gonder_o}, 32'd1);

        // Randomized traffic on a small register window to provoke hazards.
        do_reset();
        have = 0;
        cur = idle();
        for (int c = 0; c < 3000; c++) begin
            if (!have && $urandom_range(0, 3) != 0) begin
                cur = idle();
                cur.valid  = 1;
                cur.rs     = {2'd0, 3'($urandom_range(0, 7)), 2'd0, 3'($urandom_range(0, 7)),
                              2'd0, 3'($urandom_range(0, 7))};
                cur.use_   = 3'($urandom_range(0, 7));
                cur.fl     = 3'($urandom_range(0, 7));
                cur.rd     = 5'($urandom_range(0, 7));
                cur.rd_yaz = 1'($urandom_range(0, 1));
                cur.rd_fl  = 1'($urandom_range(0, 1));
                cur.cok    = ($urandom_range(0, 4) == 0);
                cur.ser    = ($urandom_range(0, 7) == 0);
                have = 1;
            end
            s = have ? cur : idle();
            s.busy  = ($urandom_range(0, 2) == 0);
            s.flush = have && ($urandom_range(0, 19) == 0);
            plist.delete();
            for (int r = 0; r < 32; r++) begin
                if (ip[r]) plist.push_back(r);
                if (fp[r]) plist.push_back(r + 32);
            end
            if (plist.size() > 0 && $urandom_range(0, 1) == 1) begin
                int pick;
                pick = plist[$urandom_range(0, plist.size() - 1)];
                s.wb_en = 1; s.wb_addr = 5'(pick % 32); s.wb_fl = (pick >= 32);
            end else if ($urandom_range(0, 7) == 0) begin
                s.wb_en = 1; s.wb_addr = 5'($urandom_range(0, 7)); s.wb_fl = 1'($urandom_range(0, 1));
            end
            step(s);
            if (m_issued || s.flush) have = 0;
        end

        // Long stall saturates the counter, then reset during DRAIN.
        do_reset();
        s = idle(); s.valid = 1; s.rd = 5'd3; s.rd_yaz = 1;
        step(s);
        s = idle(); s.valid = 1; s.use_ = 3'b001; s.rs = {5'd0, 5'd0, 5'd3};
        for (int k = 0; k < 70000; k++) step(s);
        @(negedge clk_i); chk("cnt_saturated", {16'd0, durak_sayaci_o}, 32'h0000FFFF);
        s.flush = 1;
        step(s);
        s = idle(); s.valid = 1; s.ser = 1;
        step(s);
        step(s); @(negedge clk_i); chk("pre_reset_drain", {30'd0, durum_o}, 32'd2);
        s.rst = 1;
        step(s); @(negedge clk_i);
        chk("rst_state", {30'd0, durum_o}, 32'd0);
        chk("rst_int_bm", int_bekleyen_o, 32'd0);
        chk("rst_fp_bm", float_bekleyen_o, 32'd0);
        chk("rst_cnt", {16'd0, durak_sayaci_o}, 32'd0);
        s.rst = 0;
        step(s);

        @(negedge clk_i);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
